// File: rtl/cdc_handshake_bus.sv
// cdc_handshake_bus: moves one DATA_WIDTH word at a time from clk_a_in to
// clk_b_in using a req/ack handshake. The source holds the word in a register
// that does not change while a transfer is in flight. Only the req and ack
// bits pass through synchronisers. The destination copies the held word once
// it sees the synchronised request, so every data bit is sampled together.
// FOUR_PHASE selects between a 2-phase toggle protocol and a 4-phase
// return-to-zero protocol.
`timescale 1ns/1ps
module cdc_handshake_bus #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FOUR_PHASE  = 0
) (
    input  logic                  clk_a_in,
    input  logic                  arst_a,
    input  logic                  clk_b_in,
    input  logic                  arst_b,
    input  logic                  valid_a_i,
    output logic                  ready_a_o,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    output logic                  valid_b_o,
    input  logic                  ready_b_i,
    output logic [DATA_WIDTH-1:0] data_b_o
);

    localparam bit FOUR_PH = (FOUR_PHASE != 0);

    typedef enum logic [1:0] {
        A_IDLE     = 2'd0,
        A_WAIT_ACK = 2'd1,
        A_DROP     = 2'd2
    } a_state_t;

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_VALID = 2'd1,
        B_RTZ   = 2'd2
    } b_state_t;

    // ---------------- A domain ----------------
    a_state_t                state_a_reg;
    logic                    req_reg;
    logic                    ready_a_reg;
    logic [DATA_WIDTH-1:0]   hold_reg;
    logic [SYNC_STAGES-1:0]  ack_sync_reg;
    logic                    ack_synced;

    // ---------------- B domain ----------------
    b_state_t                state_b_reg;
    logic                    ack_reg;
    logic                    req_seen_reg;
    logic                    valid_b_reg;
    logic [DATA_WIDTH-1:0]   data_b_reg;
    logic [SYNC_STAGES-1:0]  req_sync_reg;
    logic                    req_synced;
    logic                    new_req;

    assign ack_synced = ack_sync_reg[SYNC_STAGES-1];
    assign req_synced = req_sync_reg[SYNC_STAGES-1];

    // A new request is a change in parity (2-phase) or a high level (4-phase).
    assign new_req = FOUR_PH ? req_synced : (req_synced != req_seen_reg);

    assign ready_a_o = ready_a_reg;
    assign valid_b_o = valid_b_reg;
    assign data_b_o  = data_b_reg;

    // Bring ack from the B domain into clk_a_in through a shift chain.
    always_ff @(posedge clk_a_in or posedge arst_a) begin
        if (arst_a) begin
            ack_sync_reg <= '0;
        end else begin
            ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], ack_reg};
        end
    end

    // Source FSM: capture the word, raise or toggle req, and wait for the ack to come back.
    always_ff @(posedge clk_a_in or posedge arst_a) begin
        if (arst_a) begin
            state_a_reg <= A_IDLE;
            req_reg     <= 1'b0;
            ready_a_reg <= 1'b1;
            hold_reg    <= '0;
        end else begin
            case (state_a_reg)
                A_IDLE: begin
                    if (valid_a_i) begin
                        hold_reg    <= data_a_i;
                        req_reg     <= FOUR_PH ? 1'b1 : ~req_reg;
                        ready_a_reg <= 1'b0;
                        state_a_reg <= A_WAIT_ACK;
                    end
                end
                A_WAIT_ACK: begin
                    if (FOUR_PH) begin
                        if (ack_synced) begin
                            req_reg     <= 1'b0;
                            state_a_reg <= A_DROP;
                        end
                    end else if (ack_synced == req_reg) begin
                        ready_a_reg <= 1'b1;
                        state_a_reg <= A_IDLE;
                    end
                end
                A_DROP: begin
                    if (!ack_synced) begin
                        ready_a_reg <= 1'b1;
                        state_a_reg <= A_IDLE;
                    end
                end
                default: begin
                    ready_a_reg <= 1'b1;
                    state_a_reg <= A_IDLE;
                end
            endcase
        end
    end

    // Bring req from the A domain into clk_b_in through a shift chain.
    always_ff @(posedge clk_b_in or posedge arst_b) begin
        if (arst_b) begin
            req_sync_reg <= '0;
        end else begin
            req_sync_reg <= {req_sync_reg[SYNC_STAGES-2:0], req_reg};
        end
    end

    // Destination FSM: present the held word until it is accepted, then send the ack.
    always_ff @(posedge clk_b_in or posedge arst_b) begin
        if (arst_b) begin
            state_b_reg  <= B_IDLE;
            ack_reg      <= 1'b0;
            req_seen_reg <= 1'b0;
            valid_b_reg  <= 1'b0;
            data_b_reg   <= '0;
        end else begin
            case (state_b_reg)
                B_IDLE: begin
                    if (new_req) begin
                        // hold_reg has been stable since before req was raised.
                        data_b_reg   <= hold_reg;
                        valid_b_reg  <= 1'b1;
                        req_seen_reg <= req_synced;
                        state_b_reg  <= B_VALID;
                    end
                end
                B_VALID: begin
                    if (ready_b_i) begin
                        valid_b_reg <= 1'b0;
                        if (FOUR_PH) begin
                            ack_reg     <= 1'b1;
                            state_b_reg <= B_RTZ;
                        end else begin
                            // req cannot move until acked, so req_seen equals sync(req)
                            ack_reg     <= req_seen_reg;
                            state_b_reg <= B_IDLE;
                        end
                    end
                end
                B_RTZ: begin
                    if (!req_synced) begin
                        ack_reg     <= 1'b0;
                        state_b_reg <= B_IDLE;
                    end
                end
                default: begin
                    valid_b_reg <= 1'b0;
                    state_b_reg <= B_IDLE;
                end
            endcase
        end
    end

endmodule
